// File: rtl/fixed_divider_pkg.sv
// Shared constants for the iterative fixed-point divider: default widths, saturation
// limits and controller state encoding.
package fixed_divider_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int FWIDTH_DEF = 8;

  localparam logic [DWIDTH_DEF-1:0] QMAX = {1'b0, {(DWIDTH_DEF-1){1'b1}}};
  localparam logic [DWIDTH_DEF-1:0] QMIN = {1'b1, {(DWIDTH_DEF-1){1'b0}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

endpackage

// File: rtl/fixed_divider_div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, din_i};
    diff    = shifted - {1'b0, dvs_i};
    // With rem_i < dvs_i, a borrow always lands in the top bit.
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/fixed_divider.sv
// Signed Q-format divider, one restoring step per clock, fixed latency and saturating output.
module fixed_divider
  import fixed_divider_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FWIDTH = FWIDTH_DEF,
  parameter int NITER  = DWIDTH + FWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] q,
  output logic              ovf,
  output logic              dz
);

  localparam int RW = DWIDTH + 1;
  localparam int CW = $clog2(NITER + 1);

  localparam logic [DWIDTH-1:0] QPOS = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] QNEG = {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [NITER-1:0]  MPOS = {{(NITER-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic [NITER-1:0]  MNEG = MPOS + 1'b1;

  logic [1:0]        state_q;
  logic [CW-1:0]     cnt_q;
  // Low NITER bits of the aligned dividend; the top bit is always zero as |a| <= 2^(DWIDTH-1).
  logic [NITER-1:0]  dvd_q;
  logic [RW-1:0]     rem_q;
  logic [RW-1:0]     div_q;
  logic [NITER-1:0]  quo_q;
  logic              sign_q;
  logic              aneg_q;
  logic              azero_q;
  logic              bzero_q;

  logic [DWIDTH-1:0] a_mag;
  logic [RW-1:0]     b_ext;
  logic [RW-1:0]     b_mag;
  logic [RW-1:0]     rem_nx;
  logic              qbit;
  logic [DWIDTH-1:0] m_lo;
  logic [DWIDTH-1:0] res_q;
  logic              res_ovf;

  always_comb begin
    a_mag = a[DWIDTH-1] ? (~a + 1'b1) : a;
    b_ext = {b[DWIDTH-1], b};
    b_mag = b_ext[RW-1] ? (~b_ext + 1'b1) : b_ext;
  end

  div_step #(
    .WIDTH(RW)
  ) u_step (
    .rem_i (rem_q),
    .dvs_i (div_q),
    .din_i (dvd_q[NITER-1]),
    .rem_o (rem_nx),
    .qbit_o(qbit)
  );

  always_comb begin
    m_lo    = quo_q[DWIDTH-1:0];
    res_q   = '0;
    res_ovf = 1'b0;
    if (bzero_q) begin
      res_q = azero_q ? '0 : (aneg_q ? QNEG : QPOS);
    end else if (!sign_q && (quo_q > MPOS)) begin
      res_q   = QPOS;
      res_ovf = 1'b1;
    end else if (sign_q && (quo_q > MNEG)) begin
      res_q   = QNEG;
      res_ovf = 1'b1;
    end else begin
      res_q = sign_q ? (~m_lo + 1'b1) : m_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      aneg_q  <= 1'b0;
      azero_q <= 1'b0;
      bzero_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= a[DWIDTH-1] ^ b[DWIDTH-1];
            aneg_q  <= a[DWIDTH-1];
            azero_q <= (a == '0);
            bzero_q <= (b == '0);
            dvd_q   <= {a_mag, {FWIDTH{1'b0}}};
            div_q   <= b_mag;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= CW'(NITER);
            busy    <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= {quo_q[NITER-2:0], qbit};
          dvd_q <= {dvd_q[NITER-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          q       <= res_q;
          ovf     <= res_ovf;
          dz      <= bzero_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider.sv
// Directed bench for fixed_divider: a reference model fills a scoreboard on each start,
// entries are popped and compared when done pulses.
module tb_fixed_divider;
  import fixed_divider_pkg::*;

  typedef struct packed {
    logic [15:0] q;
    logic        ovf;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic        ovf;
  logic        dz;

  exp_t scb[$];
  int   ntests = 0;
  int   nfail  = 0;

  fixed_divider #(
    .DWIDTH(16),
    .FWIDTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .ovf  (ovf),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
    exp_t   e;
    longint sa, sbv, ma, mb, m;
    bit     sg;
    sa    = longint'($signed(av));
    sbv   = longint'($signed(bv));
    ma    = (sa < 0) ? -sa : sa;
    mb    = (sbv < 0) ? -sbv : sbv;
    sg    = av[15] ^ bv[15];
    e.dz  = (bv == 16'h0);
    e.ovf = 1'b0;
    if (bv == 16'h0) begin
      e.q = (av == 16'h0) ? 16'h0 : (av[15] ? QMIN : QMAX);
    end else begin
      m = (ma * 256) / mb;
      if (!sg && m > 32767) begin
        e.q   = QMAX;
        e.ovf = 1'b1;
      end else if (sg && m > 32768) begin
        e.q   = QMIN;
        e.ovf = 1'b1;
      end else begin
        e.q = sg ? 16'(-m) : 16'(m);
      end
    end
    return e;
  endfunction

  // Called at a falling edge; the start is taken on the following rising edge.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    scb.push_back(model(av, bv));
  endtask

  task automatic run(input bit inject);
    int   lat;
    int   busy_cnt;
    exp_t e;
    lat      = -1;
    busy_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (inject && (k == 5 || k == 12)) begin
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom) | 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (k == 0) check("done_low_after_start", {31'b0, done}, 32'd0);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    check("latency", lat, 32'd25);
    check("busy_cycles", busy_cnt, 32'd25);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    e = scb.pop_front();
    check("q", {16'b0, q}, {16'b0, e.q});
    check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
    check("dz", {31'b0, dz}, {31'b0, e.dz});
  endtask

  initial begin
    int   ndone;
    exp_t drop;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", {16'b0, q}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_dz", {31'b0, dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each launch happens in the done cycle of the previous op.
    launch(16'h0300, 16'h0200); run(1'b1);
    launch(16'hFD00, 16'h0200); run(1'b0);
    launch(16'h0100, 16'h0300); run(1'b0);
    launch(16'h7F00, 16'h0010); run(1'b0);
    launch(16'h8000, 16'h0080); run(1'b0);
    launch(16'hFF00, 16'h0000); run(1'b0);
    launch(16'h0000, 16'h0000); run(1'b0);
    launch(16'h8000, 16'h0100); run(1'b0);
    launch(16'h0300, 16'hFE00); run(1'b0);
    launch(16'h8000, 16'hFF00); run(1'b0);
    for (int i = 0; i < 4; i++) begin
      launch(16'($urandom), 16'($urandom) | 16'h0001);
      run(1'b0);
    end

    // Abort an operation with reset partway through.
    launch(16'h0500, 16'h0300);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_q", {16'b0, q}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    drop  = scb.pop_front();
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 32'd0);

    launch(16'h0300, 16'h0200); run(1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
